// File: rtl/kuznechik_key_schedule.sv
// Kuznechik (GOST R 34.12-2015) round-key expansion: 256-bit master key -> ten 128-bit round keys.
// Optional build macro KS_ZEROIZE_EN adds a synchronous zeroize_i input.
`timescale 1ns/1ps
module kuznechik_key_schedule #(
   parameter int N_ROUNDS = 32,
   parameter int N_KEYS   = 10
) (
   input  logic           clk_i,
   input  logic           resetn_i,
   input  logic           request_i,
   input  logic [255:0]   key_i,
`ifdef KS_ZEROIZE_EN
   input  logic           zeroize_i,
`endif
   output logic           busy_o,
   output logic           valid_o,
   input  logic [3:0]     key_idx_i,
   output logic [127:0]   key_o
);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_X, ST_S, ST_L, ST_F} state_t;

   // Linear-layer coefficients, most significant byte first.
   localparam logic [127:0] L_COEF = 128'h94208510C2C001FB01C0C21085209401;

   localparam logic [2047:0] SBOX = {
      128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
      128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
      128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
      128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
      128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
      128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
      128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
      128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
   };

   // GF(2^8) multiply modulo x^8+x^7+x^6+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] l_byte(input logic [127:0] v);
      logic [7:0] acc;
      acc = '0;
      for (int j = 0; j < 16; j++) acc = acc ^ gf_mul(v[8*j +: 8], L_COEF[8*j +: 8]);
      return acc;
   endfunction

   function automatic logic [127:0] r_step(input logic [127:0] v);
      return {l_byte(v), v[127:8]};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] v);
      logic [127:0] o;
      for (int j = 0; j < 16; j++) o[8*j +: 8] = SBOX[8*(255 - int'(v[8*j +: 8])) +: 8];
      return o;
   endfunction

   // Round constant C[idx+1] = L(idx+1); depends only on the 5-bit round, so it folds to a ROM.
   function automatic logic [127:0] c_const(input logic [4:0] idx);
      logic [127:0] v;
      v = 128'(idx) + 128'd1;
      for (int i = 0; i < 16; i++) v = r_step(v);
      return v;
   endfunction

   state_t         state;
   logic [127:0]   a1, a0, t;
   logic [4:0]     r;
   logic [3:0]     b;
   logic [127:0]   key_file [N_KEYS];
   logic [3:0]     kidx;
   logic           zeroize;

`ifdef KS_ZEROIZE_EN
   assign zeroize = zeroize_i;
`else
   assign zeroize = 1'b0;
`endif

   assign kidx = {1'b0, r[4:3], 1'b0} + 4'd2;

   // Control, counters and key file.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state   <= ST_IDLE;
         busy_o  <= 1'b0;
         valid_o <= 1'b0;
         r       <= '0;
         b       <= '0;
         for (int i = 0; i < N_KEYS; i++) key_file[i] <= '0;
      end else if (zeroize) begin
         state   <= ST_IDLE;
         busy_o  <= 1'b0;
         valid_o <= 1'b0;
         r       <= '0;
         b       <= '0;
         for (int i = 0; i < N_KEYS; i++) key_file[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: if (request_i) begin
               state   <= ST_LOAD;
               busy_o  <= 1'b1;
               valid_o <= 1'b0;
               r       <= '0;
            end
            ST_LOAD: begin
               key_file[0] <= a1;
               key_file[1] <= a0;
               state       <= ST_X;
            end
            ST_X: state <= ST_S;
            ST_S: begin
               b     <= '0;
               state <= ST_L;
            end
            ST_L: begin
               b <= b + 4'd1;
               if (b == 4'd15) state <= ST_F;
            end
            ST_F: begin
               r <= r + 5'd1;
               if (r[2:0] == 3'd7) begin
                  key_file[kidx]        <= t ^ a0;
                  key_file[kidx + 4'd1] <= a1;
               end
               if (r == 5'(N_ROUNDS - 1)) begin
                  busy_o  <= 1'b0;
                  valid_o <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  state <= ST_X;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Feistel datapath.
   always_ff @(posedge clk_i) begin
      if (zeroize) begin
         a1 <= '0;
         a0 <= '0;
         t  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (request_i) begin
               a1 <= key_i[255:128];
               a0 <= key_i[127:0];
            end
            ST_X: t <= a1 ^ c_const(r);
            ST_S: t <= sub_bytes(t);
            ST_L: t <= r_step(t);
            ST_F: begin
               a1 <= t ^ a0;
               a0 <= a1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      key_o = '0;
      if (key_idx_i < 4'(N_KEYS)) key_o = key_file[key_idx_i];
   end

endmodule

// File: tb/tb_kuznechik_key_schedule.sv
// Scoreboard bench for kuznechik_key_schedule: byte-level reference model, queued expectations, sweeping monitor.
`timescale 1ns/1ps
module tb_kuznechik_key_schedule;

   localparam logic [7:0] LV [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
   localparam logic [127:0] PI_ROWS [16] = '{
      128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
      128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
      128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
      128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
      128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
      128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
      128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
      128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};
   localparam logic [255:0] GOST_KEY =
      256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          request = 1'b0;
   logic [255:0]  key = '0;
   logic          busy_o, valid_o;
   logic [3:0]    key_idx_i;
   logic [127:0]  key_o;
   logic          chk_zero = 1'b0;
`ifdef KS_ZEROIZE_EN
   logic          zeroize = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   logic [1279:0] exp_q [$];

   kuznechik_key_schedule dut (
      .clk_i     (clk),
      .resetn_i  (resetn),
      .request_i (request),
      .key_i     (key),
`ifdef KS_ZEROIZE_EN
      .zeroize_i (zeroize),
`endif
      .busy_o    (busy_o),
      .valid_o   (valid_o),
      .key_idx_i (key_idx_i),
      .key_o     (key_o)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, want);
      end
   endtask

   // ---------------- reference model (byte arrays, long multiplication) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (c[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h1C3 << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] m_lin(input logic [127:0] x);
      logic [7:0] a [16];
      logic [7:0] s;
      logic [127:0] y;
      for (int i = 0; i < 16; i++) a[i] = x[127 - 8*i -: 8];
      for (int rnd = 0; rnd < 16; rnd++) begin
         s = '0;
         for (int i = 0; i < 16; i++) s = s ^ gmul(a[i], LV[i]);
         for (int i = 15; i > 0; i--) a[i] = a[i-1];
         a[0] = s;
      end
      for (int i = 0; i < 16; i++) y[127 - 8*i -: 8] = a[i];
      return y;
   endfunction

   function automatic logic [127:0] m_sub(input logic [127:0] x);
      logic [127:0] y;
      logic [7:0] v;
      for (int i = 0; i < 16; i++) begin
         v = x[8*i +: 8];
         y[8*i +: 8] = PI_ROWS[v[7:4]][127 - 8*int'(v[3:0]) -: 8];
      end
      return y;
   endfunction

   function automatic logic [1279:0] m_expand(input logic [255:0] mk);
      logic [127:0] k1, k2, nk, c;
      logic [1279:0] ks;
      k1 = mk[255:128];
      k2 = mk[127:0];
      ks[127:0] = k1;
      ks[255:128] = k2;
      for (int j = 0; j < 4; j++) begin
         for (int i = 1; i <= 8; i++) begin
            c  = m_lin(128'(8*j + i));
            nk = m_lin(m_sub(k1 ^ c)) ^ k2;
            k2 = k1;
            k1 = nk;
         end
         ks[128*(2*j+2) +: 128] = k1;
         ks[128*(2*j+3) +: 128] = k2;
      end
      return ks;
   endfunction

   // ---------------- monitor: sweeps all 16 indices whenever an output is presented ----------------
   initial begin
      logic [1279:0] e;
      key_idx_i = '0;
      forever begin
         @(posedge valid_o or posedge chk_zero);
         #1;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got an output event at %0t, expected none queued", $time);
         end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 16; i++) begin
               key_idx_i = 4'(i);
               #0.5;
               chk($sformatf("key_o[%0d]", i), key_o, (i < 10) ? e[128*i +: 128] : 128'h0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [255:0] rnd_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic start_req(input logic [255:0] k);
      @(negedge clk);
      key = k;
      request = 1'b1;
      @(negedge clk);
      request = 1'b0;
   endtask

   task automatic wait_cycles(input int k, input string nm);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
         if (busy_o !== 1'b1 || valid_o !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      chk({nm, "_busy_hold"}, 128'(ok), 128'd1);
   endtask

   task automatic wait_done(input int inject_at, input logic [255:0] k2, input string nm);
      int n;
      logic ok;
      n = 0;
      ok = 1'b1;
      while (valid_o !== 1'b1 && n < 700) begin
         if (busy_o !== 1'b1) ok = 1'b0;
         if (n == inject_at) begin
            key = k2;
            request = 1'b1;
         end else begin
            request = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      request = 1'b0;
      chk({nm, "_latency"}, 128'(n), 128'd609);
      chk({nm, "_busy_during"}, 128'(ok), 128'd1);
      chk({nm, "_busy_end"}, 128'(busy_o), 128'd0);
   endtask

   task automatic zero_sweep();
      exp_q.push_back('0);
      chk_zero = 1'b1;
      #10;
      chk_zero = 1'b0;
   endtask

   initial begin
      logic [1279:0] g;
      logic [255:0] k;

      #1 resetn = 1'b0;
      #2;
      chk("reset_busy", 128'(busy_o), 128'd0);
      chk("reset_valid", 128'(valid_o), 128'd0);
      zero_sweep();
      @(negedge clk);
      resetn = 1'b1;

      // GOST vector; indices 0, 2, 9 against the published round keys
      g = m_expand(GOST_KEY);
      g[0 +: 128]    = 128'h8899aabbccddeeff0011223344556677;
      g[256 +: 128]  = 128'hdb31485315694343228d6aef8cc78c44;
      g[1152 +: 128] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
      start_req(GOST_KEY);
      exp_q.push_back(g);
      wait_done(-1, '0, "gost");

      // second request with another key while busy is ignored
      start_req(GOST_KEY);
      exp_q.push_back(g);
      wait_done(100, rnd_key(), "busy_guard");

      // request held across the completing edge: accepted only on the following idle edge
      k = rnd_key();
      start_req(k);
      exp_q.push_back(m_expand(k));
      wait_cycles(608, "b2b");
      key = '0;
      request = 1'b1;
      @(negedge clk);
      chk("b2b_valid_rise", 128'(valid_o), 128'd1);
      chk("b2b_not_taken", 128'(busy_o), 128'd0);
      @(negedge clk);
      request = 1'b0;
      chk("b2b_valid_drop", 128'(valid_o), 128'd0);
      chk("b2b_busy_rise", 128'(busy_o), 128'd1);
      exp_q.push_back(m_expand('0));
      wait_done(-1, '0, "zero_key");

      // async reset in the middle of round 17
      start_req(rnd_key());
      wait_cycles(330, "abort");
      #2 resetn = 1'b0;
      #1;
      chk("abort_busy", 128'(busy_o), 128'd0);
      chk("abort_valid", 128'(valid_o), 128'd0);
      zero_sweep();
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 2; i++) begin
         k = rnd_key();
         start_req(k);
         exp_q.push_back(m_expand(k));
         wait_done(-1, '0, $sformatf("rand%0d", i));
      end

`ifdef KS_ZEROIZE_EN
      @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      chk("zero_valid", 128'(valid_o), 128'd0);
      chk("zero_busy", 128'(busy_o), 128'd0);
      zero_sweep();
      start_req(rnd_key());
      wait_cycles(100, "zero_mid");
      zeroize = 1'b1;
      request = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      request = 1'b0;
      chk("zero_mid_busy", 128'(busy_o), 128'd0);
      chk("zero_mid_valid", 128'(valid_o), 128'd0);
      @(negedge clk);
      chk("zero_no_restart", 128'(busy_o), 128'd0);
      zero_sweep();
`endif

      #20;
      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
